// File: rtl/universal_ff_reg_if.sv
// Control, data and status bundle for the universal flip-flop bank.
// The master drives the mode, enable and data inputs. The slave returns the state and the illegal-event status.
interface universal_ff_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             changed;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output en, mode, a, b, clr_err,
    input  q, q_bar, changed, illegal, illegal_cnt
  );

  modport slave (
    input  en, mode, a, b, clr_err,
    output q, q_bar, changed, illegal, illegal_cnt
  );
endinterface

// File: rtl/universal_ff_reg.sv
// Bank of WIDTH flip-flops whose SR/JK/D/T behaviour is selected per edge. The new state appears one edge after the inputs are sampled.
// There is no backpressure. It also keeps a sticky flag and a saturating count of SR S=R=1 edges.
module universal_ff_reg #(
  parameter int WIDTH     = 8,
  parameter int SR_POLICY = 0,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst,
  universal_ff_reg_if.slave bus
);
  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_evt;

  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (bus.mode)
          MODE_SR: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11: begin
                // Policy 0 leaves the bit as it was.
                if (SR_POLICY == 1)      q_d[i] = 1'b1;
                else if (SR_POLICY == 2) q_d[i] = 1'b0;
              end
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_D:  q_d[i] = bus.a[i];
          MODE_T:  q_d[i] = q_q[i] ^ bus.a[i];
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  always_comb begin
    illegal_evt = bus.en && (bus.mode == MODE_SR) && (|(bus.a & bus.b));
    changed_d   = (q_d != q_q);
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    // A new illegal event takes priority over a clear on the same edge.
    if (illegal_evt) begin
      illegal_d = 1'b1;
      if (bus.clr_err)           cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.clr_err) begin
      illegal_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q       <= '0;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.q_bar       = ~q_q;
  assign bus.changed     = changed_q;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_universal_ff_reg.sv
// Drives three banks with SR_POLICY 0, 1 and 2 in lock-step from the same stimulus.
// Each bank is checked against a per-bit characteristic-equation model.
module tb_universal_ff_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  universal_ff_reg_if #(.WIDTH(8), .CNT_W(8)) i0 ();
  universal_ff_reg_if #(.WIDTH(8), .CNT_W(8)) i1 ();
  universal_ff_reg_if #(.WIDTH(8), .CNT_W(8)) i2 ();

  universal_ff_reg #(.WIDTH(8), .SR_POLICY(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
  universal_ff_reg #(.WIDTH(8), .SR_POLICY(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(i1));
  universal_ff_reg #(.WIDTH(8), .SR_POLICY(2), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(i2));

  logic [7:0] dq[3], dqb[3], dcn[3];
  logic       dch[3], dil[3];
  assign dq[0] = i0.q;  assign dqb[0] = i0.q_bar;  assign dch[0] = i0.changed;
  assign dil[0] = i0.illegal; assign dcn[0] = i0.illegal_cnt;
  assign dq[1] = i1.q;  assign dqb[1] = i1.q_bar;  assign dch[1] = i1.changed;
  assign dil[1] = i1.illegal; assign dcn[1] = i1.illegal_cnt;
  assign dq[2] = i2.q;  assign dqb[2] = i2.q_bar;  assign dch[2] = i2.changed;
  assign dil[2] = i2.illegal; assign dcn[2] = i2.illegal_cnt;

  logic [7:0] mq[3];
  bit         mchg[3], mill[3];
  int         mcnt[3];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Characteristic equations: SR Q+ = S | ~R&Q (S=R=1 per policy), JK Q+ = J&~Q | ~K&Q.
  function automatic logic [7:0] model_next(int pol, logic [7:0] q, logic [1:0] mode,
                                            logic [7:0] a, logic [7:0] b);
    logic [7:0] keep;
    keep = (pol == 1) ? 8'hFF : (pol == 2) ? 8'h00 : q;
    case (mode)
      2'd0:    return (a & ~b) | (q & ~a & ~b) | (a & b & keep);
      2'd1:    return (a & ~q) | (~b & q);
      2'd2:    return a;
      default: return q ^ a;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      mq[p] = 8'h00; mchg[p] = 1'b0; mill[p] = 1'b0; mcnt[p] = 0;
    end
  endtask

  task automatic step(input logic en, input logic [1:0] mode, input logic [7:0] a,
                      input logic [7:0] b, input logic clr);
    logic [7:0] nq;
    bit         ev;
    @(negedge clk);
    i0.en = en; i0.mode = mode; i0.a = a; i0.b = b; i0.clr_err = clr;
    i1.en = en; i1.mode = mode; i1.a = a; i1.b = b; i1.clr_err = clr;
    i2.en = en; i2.mode = mode; i2.a = a; i2.b = b; i2.clr_err = clr;
    @(posedge clk);
    if (rst) begin
      ev = en && (mode == 2'd0) && ((a & b) != 8'h00);
      for (int p = 0; p < 3; p++) begin
        nq = en ? model_next(p, mq[p], mode, a, b) : mq[p];
        mchg[p] = (nq != mq[p]);
        mq[p] = nq;
        if (ev) begin
          mill[p] = 1'b1;
          mcnt[p] = clr ? 1 : ((mcnt[p] >= 255) ? 255 : mcnt[p] + 1);
        end else if (clr) begin
          mill[p] = 1'b0;
          mcnt[p] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int p = 0; p < 3; p++) begin
      n_tests++;
      if ({dq[p], dqb[p], dch[p], dil[p], dcn[p]} !== {8'h00, 8'hFF, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL reset p%0d: got q=%h qb=%h ch=%b il=%b cnt=%0d, want 00 ff 0 0 0",
                 p, dq[p], dqb[p], dch[p], dil[p], dcn[p]);
      end
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_d();
    step(1, 2'd2, 8'hA5, 8'h00, 0);
    n_tests++;
    if ({dq[0], dqb[0], dch[0]} !== {8'hA5, 8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL d_load: got q=%h qb=%h ch=%b, want a5 5a 1", dq[0], dqb[0], dch[0]);
    end
    step(1, 2'd2, 8'hA5, 8'h3C, 0);
    n_tests++;
    if ({dq[0], dch[0]} !== {8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL d_same: got q=%h ch=%b, want a5 0", dq[0], dch[0]);
    end
  endtask

  task automatic test_jk();
    step(1, 2'd2, 8'h0F, 8'h00, 0);
    step(1, 2'd1, 8'hFF, 8'hFF, 0);
    n_tests++;
    if (dq[0] !== 8'hF0) begin
      n_fail++; $display("FAIL jk_toggle: got q=%h, want f0", dq[0]);
    end
    step(1, 2'd1, 8'h01, 8'h02, 0);
    n_tests++;
    if (dq[0] !== 8'hF1) begin
      n_fail++; $display("FAIL jk_setclr: got q=%h, want f1", dq[0]);
    end
  endtask

  task automatic test_sr();
    logic [7:0] want_q[3];
    step(1, 2'd2, 8'h00, 8'h00, 0);
    step(1, 2'd0, 8'h03, 8'h01, 0);
    want_q[0] = 8'h02; want_q[1] = 8'h03; want_q[2] = 8'h02;
    for (int p = 0; p < 3; p++) begin
      n_tests++;
      if ({dq[p], dil[p], dcn[p]} !== {want_q[p], 1'b1, 8'd1}) begin
        n_fail++;
        $display("FAIL sr_illegal p%0d: got q=%h il=%b cnt=%0d, want %h 1 1",
                 p, dq[p], dil[p], dcn[p], want_q[p]);
      end
    end
    for (int k = 0; k < 300; k++) step(1, 2'd0, 8'h03, 8'h01, 0);
    n_tests++;
    if ({dil[0], dcn[0]} !== {1'b1, 8'd255}) begin
      n_fail++; $display("FAIL sr_saturate: got il=%b cnt=%0d, want 1 255", dil[0], dcn[0]);
    end
    step(0, 2'd0, 8'hFF, 8'hFF, 1);
    n_tests++;
    if ({dq[0], dil[0], dcn[0]} !== {8'h02, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL clr_err: got q=%h il=%b cnt=%0d, want 02 0 0", dq[0], dil[0], dcn[0]);
    end
    step(1, 2'd2, 8'h00, 8'h00, 0);
    step(1, 2'd0, 8'hFF, 8'hFF, 0);
    want_q[0] = 8'h00; want_q[1] = 8'hFF; want_q[2] = 8'h00;
    for (int p = 0; p < 3; p++) begin
      n_tests++;
      if (dq[p] !== want_q[p]) begin
        n_fail++; $display("FAIL sr_policy p%0d: got q=%h, want %h", p, dq[p], want_q[p]);
      end
    end
    step(1, 2'd0, 8'hFF, 8'hFF, 1);
    for (int p = 0; p < 3; p++) begin
      n_tests++;
      if ({dil[p], dcn[p]} !== {1'b1, 8'd1}) begin
        n_fail++; $display("FAIL clr_vs_set p%0d: got il=%b cnt=%0d, want 1 1", p, dil[p], dcn[p]);
      end
    end
  endtask

  task automatic test_t_en();
    logic [7:0] want[4];
    want[0] = 8'h81; want[1] = 8'h81; want[2] = 8'h00; want[3] = 8'h00;
    step(1, 2'd2, 8'h00, 8'h00, 0);
    for (int k = 0; k < 4; k++) begin
      step(k % 2 == 0, 2'd3, 8'h81, 8'hFF, 0);
      n_tests++;
      if ({dq[0], dch[0]} !== {want[k], (k % 2 == 0)}) begin
        n_fail++;
        $display("FAIL t_en edge%0d: got q=%h ch=%b, want %h %b", k, dq[0], dch[0], want[k], k % 2 == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(3, 0) != 0, 2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom),
           $urandom_range(7, 0) == 0);
      for (int p = 0; p < 3; p++) begin
        n_tests++;
        if ({dq[p], dqb[p], dch[p], dil[p], dcn[p]} !== {mq[p], ~mq[p], mchg[p], mill[p], 8'(mcnt[p])}) begin
          n_fail++;
          $display("FAIL random it%0d p%0d: got q=%h qb=%h ch=%b il=%b cnt=%0d, want %h %h %b %b %0d",
                   k, p, dq[p], dqb[p], dch[p], dil[p], dcn[p],
                   mq[p], ~mq[p], mchg[p], mill[p], mcnt[p]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 2'd2, 8'hFF, 8'h00, 0);
    step(1, 2'd0, 8'h01, 8'h01, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int p = 0; p < 3; p++) begin
      n_tests++;
      if ({dq[p], dqb[p], dch[p], dil[p], dcn[p]} !== {8'h00, 8'hFF, 1'b0, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL async_rst p%0d: got q=%h qb=%h ch=%b il=%b cnt=%0d, want 00 ff 0 0 0",
                 p, dq[p], dqb[p], dch[p], dil[p], dcn[p]);
      end
    end
    step(1, 2'd2, 8'h55, 8'h00, 0);
    n_tests++;
    if (dq[0] !== 8'h00) begin
      n_fail++; $display("FAIL rst_hold: got q=%h, want 00", dq[0]);
    end
    @(negedge clk); rst = 1'b1;
    step(1, 2'd2, 8'h3C, 8'h00, 0);
    n_tests++;
    if ({dq[0], dch[0]} !== {8'h3C, 1'b1}) begin
      n_fail++; $display("FAIL rst_release: got q=%h ch=%b, want 3c 1", dq[0], dch[0]);
    end
  endtask

  initial begin
    i0.en = 0; i0.mode = 0; i0.a = 0; i0.b = 0; i0.clr_err = 0;
    i1.en = 0; i1.mode = 0; i1.a = 0; i1.b = 0; i1.clr_err = 0;
    i2.en = 0; i2.mode = 0; i2.a = 0; i2.b = 0; i2.clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_d();
    test_jk();
    test_sr();
    test_t_en();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/universal_ff_reg.md
UNIVERSAL_FF_REG -- requirements
Module: universal_ff_reg

Interface
REQ-001 Parameter WIDTH, default 8: number of independent flip-flop bits.
REQ-002 Parameter SR_POLICY, default 0: SR-mode response to S=R=1; 0 hold, 1 set wins, 2 reset wins.
REQ-003 Parameter CNT_W, default 8: width of illegal-event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  update enable; 0 = all state holds.
REQ-007 mode  input  2  bank-wide FF mode: 00 SR, 01 JK, 10 D, 11 T.
REQ-008 a  input  WIDTH  per-bit primary input (S / J / D / T).
REQ-009 b  input  WIDTH  per-bit secondary input (R / K; ignored in D, T).
REQ-010 clr_err  input  1  synchronous clear of illegal and illegal_cnt.
REQ-011 q  output  WIDTH  registered state.
REQ-012 q_bar  output  WIDTH  bitwise complement of q.
REQ-013 changed  output  1  registered pulse: q changed on previous edge.
REQ-014 illegal  output  1  sticky flag: SR-mode S=R=1 seen.
REQ-015 illegal_cnt  output  CNT_W  saturating count of illegal edges.

Function
REQ-016 q SHALL update on rising clk only when en=1; mode and inputs sampled at that edge, zero-latency mode switch.
REQ-017 SR per bit (a,b): 00 hold, 01 clear, 10 set, 11 per SR_POLICY.
REQ-018 JK per bit (a,b): 00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 D: q[i] <= a[i]; b ignored.
REQ-020 T: a[i]=1 toggles q[i], a[i]=0 holds; b ignored.
REQ-021 q_bar SHALL equal ~q combinationally at all times, including during reset.
REQ-022 changed SHALL be 1 for exactly the cycle after an edge where next q != current q; else 0; en=0 edge drives changed=0.
REQ-023 Illegal event: edge with en=1, mode=00, and (a & b) != 0 on any bit; counted once per edge regardless of bit count.
REQ-024 illegal SHALL set on an illegal event and stay set until clr_err=1 or reset.
REQ-025 illegal_cnt SHALL increment by 1 per illegal event, saturating at 2^CNT_W-1 (no wrap).
REQ-026 clr_err=1 with no illegal event: illegal=0, illegal_cnt=0 next cycle.
REQ-027 clr_err=1 coincident with illegal event: illegal=1, illegal_cnt=1 (set wins).
REQ-028 clr_err SHALL act regardless of en; it SHALL NOT affect q.
REQ-029 Illegal event with SR_POLICY=0 SHALL still apply non-illegal bits' SR actions normally.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force q=0, changed=0, illegal=0, illegal_cnt=0; q_bar=all ones.
REQ-031 Reset asserted mid-operation SHALL override any pending update; first update occurs on first rising edge with rst=1.
REQ-032 No output SHALL be X after reset regardless of input state.

Verification (WIDTH=8, CNT_W=8 unless stated)
REQ-033 Reset then D mode, en=1, a=8'hA5 one edge -> q=8'hA5, q_bar=8'h5A, changed=1 next cycle, then a=8'hA5 again -> changed=0.
REQ-034 q=8'h0F, mode=JK, a=8'hFF, b=8'hFF -> q=8'hF0; a=8'h01, b=8'h02 -> q=8'hF1 (bit0 set, bit1 cleared).
REQ-035 SR_POLICY=0, q=8'h00, mode=SR, a=8'h03, b=8'h01 -> q=8'h02, illegal=1, illegal_cnt=1; repeat 300 edges -> illegal_cnt=255 held.
REQ-036 SR_POLICY=1 and 2, q=8'h00, a=b=8'hFF -> q=8'hFF and q=8'h00 respectively; clr_err with simultaneous illegal event -> illegal=1, cnt=1.
REQ-037 T mode, a=8'h81, en toggled 1/0 alternately over 4 edges -> q toggles only on en=1 edges (8'h81, 8'h81, 8'h00, 8'h00).
REQ-038 rst driven low between edges with q=8'hFF, illegal=1 -> q=0, q_bar=8'hFF, illegal=0, cnt=0 before next edge.
